dip_switch_input_port: RTL
==========================

// Module: dip_switch_input_port
// PURPOSE
//  Input-direction companion to the GPIO board display path: synchronises and debounces the
//  32 GPIO-board DIP switches and answers LEGv8 memory-mapped loads with their settled value.
//  Sits between the GPIO board's DIP_SW output and the processor data bus.
//  Output path: processor -> displays. This path: switches -> processor.
// PARAMETERS
//  WIDTH          32          number of switch inputs
//  BASE_ADDR      32'hFFFF0000  byte base of the 16-byte register window; bits [3:0] must be 0
//  SAMPLE_CYCLES  20000       clock cycles between debounce samples (1 ms at 20 MHz); >= 2
// PORTS
//  clock        in   1      system clock; all logic on rising edge
//  reset        in   1      asynchronous, active-low reset (asserted when 0)
//  sw_raw       in   WIDTH  raw, asynchronous switch levels
//  address      in   32     processor byte address
//  mem_read     in   1      processor load request; qualified by address match
//  read_data    out  64     load response data; valid only while read_valid = 1
//  read_valid   out  1      one-cycle pulse marking a load response
//  sw_state     out  WIDTH  debounced switch levels, for direct wiring to other logic
//  sw_changed   out  1      one-cycle pulse when any debounced bit changes
// BEHAVIOUR
//  Reset (reset=0): all flops clear. read_data=0, read_valid=0, sw_state=0, sw_changed=0,
//   sample counter=0, handshake FSM=IDLE. Reset takes effect mid-transaction; a pending
//   response is dropped.
//  Sync: each sw_raw bit passes through 2 flops before any other use.
//  Tick: the counter runs 0..SAMPLE_CYCLES-1 and wraps. tick=1 on the wrap cycle.
//  Debounce: on each tick, each bit shifts its synced level into a 3-deep history.
//   sw_state[i] updates to that level only when all 3 history entries agree.
//   Latency from a stable input change to sw_state: 2 sync cycles + 3 to 4 ticks.
//   Chatter shorter than 3 consecutive ticks never reaches sw_state.
//  sw_changed = 1 in the cycle after sw_state differs from its previous value.
//  Hit: mem_read=1 and address[31:4]==BASE_ADDR[31:4].
//  Register map, offset address[3:0]:
//   0x0  {zeros, sw_state}
//   0x8  edge-capture register (see CONFIGURATION)
//   any other offset reads 64'h0
//  FSM states IDLE and RESP:
//   IDLE --hit--> RESP. read_data is registered in this cycle.
//   RESP: read_valid=1 for exactly 1 cycle, then the FSM returns to IDLE.
//   A hit while in RESP is ignored. At most one response is outstanding.
//   Back-to-back requests get responses every 2nd cycle.
//  read_data returns to 0 when read_valid=0.
//  A non-hit mem_read gets no response.
//  The read snapshot is taken in the request cycle. A debounce update in that same cycle
//   is not visible to the read.
// CONFIGURATION
//  DIP_EDGE_CAPTURE_EN defined:
//   - Adds the WIDTH-bit sticky register at offset 0x8.
//   - Bit i sets on any sw_state[i] transition.
//   - The register clears when a response for offset 0x8 is issued.
//   - If a set and the clear occur in the same cycle, the set wins.
//   - Reset value is 0.
//  DIP_EDGE_CAPTURE_EN undefined: no register is built and offset 0x8 reads 0.
// STRUCTURE
//  Shared package legv8_io_pkg:
//   - IO_DATA_W = 64
//   - offset constants DIP_OFF_LEVEL = 4'h0 and DIP_OFF_EDGE = 4'h8
//   - enum type io_rsp_state_t {IO_IDLE, IO_RESP}
//  Sub-module debounce_bit (clock, reset, din_sync, tick -> dout): 3-deep history plus
//   settled flop. Instantiated WIDTH times with a generate loop.
//  The tick counter, FSM and register map live in the top of this block.
// TESTING
//  1. SAMPLE_CYCLES=4. Hold sw_raw=32'h0000_00A5 for 20 cycles.
//     -> sw_state=32'hA5 and one sw_changed pulse.
//  2. After test 1: mem_read=1 at BASE_ADDR+0 for 1 cycle.
//     -> the next cycle has read_valid=1 and read_data=64'h0000_0000_0000_00A5.
//  3. Toggle sw_raw[0] every 5 cycles with SAMPLE_CYCLES=4.
//     -> sw_state[0] never changes and sw_changed stays 0.
//  4. Hold mem_read=1 at BASE_ADDR+0 for 4 cycles.
//     -> exactly 2 read_valid pulses, in alternate cycles.
//     Also read BASE_ADDR+4.
//     -> read_data=0.
//     Also read address 32'h0000_1000.
//     -> no read_valid.
//  5. Build with DIP_EDGE_CAPTURE_EN. Flip bit 3 and let it settle, then read offset 0x8.
//     -> 64'h8. An immediate re-read returns 0.
//     Build without the macro.
//     -> offset 0x8 returns 0.
//  6. Drive reset=0 in the request cycle of a hit.
//     -> no read_valid. read_data=0, sw_state=0 and FSM=IDLE, all asynchronously.

Source files
------------

// File: rtl/legv8_io_pkg.sv
// Shared definitions for LEGv8 memory-mapped I/O blocks: bus data width,
// register-window offsets and the load-response handshake states.
package legv8_io_pkg;
  localparam int         IO_DATA_W     = 64;
  localparam logic [3:0] DIP_OFF_LEVEL = 4'h0;
  localparam logic [3:0] DIP_OFF_EDGE  = 4'h8;

  typedef enum logic {IO_IDLE, IO_RESP} io_rsp_state_t;
endpackage

// File: rtl/dip_switch_input_port_debounce_bit.sv
// Single-bit debouncer: a 3-sample history shifted on each tick and a settled
// output flop that follows the input only when all three samples agree.
module debounce_bit (
  input  logic clock,
  input  logic reset,
  input  logic din_sync,
  input  logic tick,
  output logic dout
);
  logic [2:0] r_hist;
  logic       r_dout;
  logic [2:0] w_hist_next;

  assign w_hist_next = {r_hist[1:0], din_sync};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hist <= 3'b000;
      r_dout <= 1'b0;
    end else if (tick) begin
      r_hist <= w_hist_next;
      if (w_hist_next == 3'b111 || w_hist_next == 3'b000)
        r_dout <= din_sync;
    end
  end

  assign dout = r_dout;
endmodule

// File: rtl/dip_switch_input_port.sv
// DIP switch input port: 2-flop sync, tick-sampled debounce and a 16-byte
// memory-mapped load window. Optional sticky edge register: DIP_EDGE_CAPTURE_EN.
module dip_switch_input_port
  import legv8_io_pkg::*;
#(
  parameter int          WIDTH         = 32,
  parameter logic [31:0] BASE_ADDR     = 32'hFFFF0000,
  parameter int          SAMPLE_CYCLES = 20000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     sw_raw,
  input  logic [31:0]          address,
  input  logic                 mem_read,
  output logic [IO_DATA_W-1:0] read_data,
  output logic                 read_valid,
  output logic [WIDTH-1:0]     sw_state,
  output logic                 sw_changed
);
  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  logic [WIDTH-1:0]     r_sync1, r_sync2;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_tick;
  logic [WIDTH-1:0]     w_deb;
  logic [WIDTH-1:0]     r_sw_prev;
  logic [WIDTH-1:0]     w_diff;
  logic                 r_changed;
  logic                 w_hit;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_edge_val;
  logic [IO_DATA_W-1:0] w_rd_mux;
  io_rsp_state_t        r_state;
  logic [IO_DATA_W-1:0] r_rd_data;
  logic                 r_rd_vld;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_cnt == CNT_W'(SAMPLE_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_deb
    debounce_bit u_deb (
      .clock    (clock),
      .reset    (reset),
      .din_sync (r_sync2[g]),
      .tick     (w_tick),
      .dout     (w_deb[g])
    );
  end

  // Change detect against last cycle's settled value; pulse lands one cycle later.
  assign w_diff = w_deb ^ r_sw_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sw_prev <= '0;
      r_changed <= 1'b0;
    end else begin
      r_sw_prev <= w_deb;
      r_changed <= |w_diff;
    end
  end

  assign w_hit    = mem_read && (address[31:4] == BASE_ADDR[31:4]);
  assign w_accept = w_hit && (r_state == IO_IDLE);

`ifdef DIP_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] r_edge;
  logic             w_edge_clr;

  // Snapshot reads the pre-clear value; a transition in the clear cycle survives.
  assign w_edge_clr = w_accept && (address[3:0] == DIP_OFF_EDGE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_edge <= '0;
    else        r_edge <= (w_edge_clr ? '0 : r_edge) | w_diff;
  end

  assign w_edge_val = r_edge;
`else
  assign w_edge_val = '0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (address[3:0])
      DIP_OFF_LEVEL: w_rd_mux = IO_DATA_W'(w_deb);
      DIP_OFF_EDGE:  w_rd_mux = IO_DATA_W'(w_edge_val);
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IO_IDLE;
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      case (r_state)
        IO_IDLE: begin
          if (w_accept) begin
            r_state   <= IO_RESP;
            r_rd_data <= w_rd_mux;
            r_rd_vld  <= 1'b1;
          end
        end
        IO_RESP: begin
          r_state   <= IO_IDLE;
          r_rd_data <= '0;
          r_rd_vld  <= 1'b0;
        end
        default: begin
          r_state   <= IO_IDLE;
          r_rd_data <= '0;
          r_rd_vld  <= 1'b0;
        end
      endcase
    end
  end

  assign read_data  = r_rd_data;
  assign read_valid = r_rd_vld;
  assign sw_state   = w_deb;
  assign sw_changed = r_changed;
endmodule
